// File: rtl/reg_file_mp.sv
// Multi-port register file with zero register, write-to-read bypass
// and a per-register busy scoreboard for decode hazard detection.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  IN,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  INADDRESS,
    input  logic [NUM_WRITE-1:0]             WRITE,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   OUTADDRESS,
    output logic [NUM_READ*DATA_WIDTH-1:0]   OUT,
    output logic [NUM_READ-1:0]              OUT_BUSY,
    input  logic                             BUSY_SET,
    input  logic [ADDR_WIDTH-1:0]            BUSY_ADDR,
    output logic                             ANY_BUSY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;

    logic [DATA_WIDTH-1:0] wdata [NUM_WRITE];
    logic [ADDR_WIDTH-1:0] waddr [NUM_WRITE];
    logic [NUM_WRITE-1:0]  wkeep;

    for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wr
        assign wdata[w] = IN[w*DATA_WIDTH +: DATA_WIDTH];
        assign waddr[w] = INADDRESS[w*ADDR_WIDTH +: ADDR_WIDTH];
        assign wkeep[w] = WRITE[w] &&
                          !((ZERO_REG != 0) && (waddr[w] == '0));
    end

    logic busy_ok;
    assign busy_ok = BUSY_SET &&
                     !((ZERO_REG != 0) && (BUSY_ADDR == '0));

    // Higher write ports are visited last, so they win a conflict;
    // busy-set follows the clears so a new producer stays pending.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wkeep[w]) begin
                    regs[waddr[w]] <= wdata[w];
                    busy[waddr[w]] <= 1'b0;
                end
            end
            if (busy_ok) begin
                busy[BUSY_ADDR] <= 1'b1;
            end
        end
    end

    for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] raddr;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  hit;
        logic                  zero;

        assign raddr = OUTADDRESS[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero  = (ZERO_REG != 0) && (raddr == '0);

        always_comb begin
            rdata = regs[raddr];
            hit   = 1'b0;
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (WRITE[w] && (waddr[w] == raddr)) begin
                    hit = 1'b1;
                    if (BYPASS != 0) begin
                        rdata = wdata[w];
                    end
                end
            end
            if (zero) begin
                rdata = '0;
            end
        end

        assign OUT[r*DATA_WIDTH +: DATA_WIDTH] = RESET ? rdata : '0;
        assign OUT_BUSY[r] = RESET && busy[raddr] && !hit && !zero;
    end

    assign ANY_BUSY = RESET && (|busy);

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: reset, writes, zero register,
// write conflicts, bypass, scoreboard and asynchronous reset.
module tb_reg_file_mp;

    logic        CLK;
    logic        RESET;
    logic [63:0] IN;
    logic [9:0]  INADDRESS;
    logic [1:0]  WRITE;
    logic [9:0]  OUTADDRESS;
    logic [63:0] OUT;
    logic [1:0]  OUT_BUSY;
    logic        BUSY_SET;
    logic [4:0]  BUSY_ADDR;
    logic        ANY_BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_mp dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN         (IN),
        .INADDRESS  (INADDRESS),
        .WRITE      (WRITE),
        .OUTADDRESS (OUTADDRESS),
        .OUT        (OUT),
        .OUT_BUSY   (OUT_BUSY),
        .BUSY_SET   (BUSY_SET),
        .BUSY_ADDR  (BUSY_ADDR),
        .ANY_BUSY   (ANY_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WRITE    = 2'b00;
        BUSY_SET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        idle();
        IN = '0;
        INADDRESS = '0;
        BUSY_ADDR = '0;
        #2;
        for (int a = 0; a < 32; a++) begin
            OUTADDRESS = {a[4:0], a[4:0]};
            #1;
            n_checks++;
            if (OUT !== 64'd0 || OUT_BUSY !== 2'b00 || ANY_BUSY !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_read a=%0d out=%h busy=%b any=%b want 0/00/0",
                         a, OUT, OUT_BUSY, ANY_BUSY);
            end
        end
        tick();
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_write();
        IN = {32'd0, 32'd95};
        INADDRESS = {5'd0, 5'd2};
        WRITE = 2'b01;
        tick();
        idle();
        OUTADDRESS = {5'd2, 5'd2};
        #1;
        n_checks++;
        if (OUT !== {32'd95, 32'd95}) begin
            n_fail++;
            $display("FAIL write_x2 got %h want %h", OUT, {32'd95, 32'd95});
        end
    endtask

    task automatic test_zero_reg();
        IN = {32'd0, 32'hDEADBEEF};
        INADDRESS = {5'd0, 5'd0};
        WRITE = 2'b01;
        OUTADDRESS = {5'd2, 5'd0};
        #1;
        n_checks++;
        if (OUT[31:0] !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_bypass got %h want 0", OUT[31:0]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (OUT[31:0] !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_stored got %h want 0", OUT[31:0]);
        end
    endtask

    task automatic test_conflict();
        IN = {32'd15, 32'd6};
        INADDRESS = {5'd4, 5'd4};
        WRITE = 2'b11;
        OUTADDRESS = {5'd0, 5'd4};
        #1;
        n_checks++;
        if (OUT[31:0] !== 32'd15) begin
            n_fail++;
            $display("FAIL conflict_bypass got %0d want 15", OUT[31:0]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (OUT[31:0] !== 32'd15) begin
            n_fail++;
            $display("FAIL conflict_stored got %0d want 15", OUT[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        BUSY_SET = 1'b1;
        BUSY_ADDR = 5'd5;
        OUTADDRESS = {5'd5, 5'd5};
        #1;
        n_checks++;
        if (OUT_BUSY !== 2'b00 || ANY_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_set_early got %b/%b want 00/0", OUT_BUSY, ANY_BUSY);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (OUT_BUSY !== 2'b11 || ANY_BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_set got %b/%b want 11/1", OUT_BUSY, ANY_BUSY);
        end
        IN = {32'd28, 32'd0};
        INADDRESS = {5'd5, 5'd0};
        WRITE = 2'b10;
        #1;
        n_checks++;
        if (OUT_BUSY !== 2'b00 || OUT !== {32'd28, 32'd28}) begin
            n_fail++;
            $display("FAIL busy_clear_cycle got %b/%h want 00/%h",
                     OUT_BUSY, OUT, {32'd28, 32'd28});
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (ANY_BUSY !== 1'b0 || OUT !== {32'd28, 32'd28}) begin
            n_fail++;
            $display("FAIL busy_cleared got %b/%h want 0/%h",
                     ANY_BUSY, OUT, {32'd28, 32'd28});
        end
        BUSY_SET = 1'b1;
        BUSY_ADDR = 5'd5;
        IN = {32'd0, 32'd77};
        INADDRESS = {5'd0, 5'd5};
        WRITE = 2'b01;
        tick();
        idle();
        #1;
        n_checks++;
        if (OUT_BUSY !== 2'b11 || ANY_BUSY !== 1'b1 || OUT[31:0] !== 32'd77) begin
            n_fail++;
            $display("FAIL set_beats_clear got %b/%b/%0d want 11/1/77",
                     OUT_BUSY, ANY_BUSY, OUT[31:0]);
        end
        BUSY_SET = 1'b1;
        BUSY_ADDR = 5'd0;
        OUTADDRESS = {5'd0, 5'd0};
        tick();
        idle();
        #1;
        n_checks++;
        if (OUT_BUSY !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_never_busy got %b want 00", OUT_BUSY);
        end
    endtask

    task automatic test_back_to_back();
        IN = {32'd111, 32'd100};
        INADDRESS = {5'd11, 5'd10};
        WRITE = 2'b11;
        tick();
        IN = {32'd133, 32'd122};
        INADDRESS = {5'd13, 5'd12};
        OUTADDRESS = {5'd11, 5'd10};
        #1;
        n_checks++;
        if (OUT !== {32'd111, 32'd100}) begin
            n_fail++;
            $display("FAIL b2b_first got %h want %h", OUT, {32'd111, 32'd100});
        end
        tick();
        idle();
        OUTADDRESS = {5'd13, 5'd12};
        #1;
        n_checks++;
        if (OUT !== {32'd133, 32'd122}) begin
            n_fail++;
            $display("FAIL b2b_second got %h want %h", OUT, {32'd133, 32'd122});
        end
    endtask

    task automatic test_async_reset();
        IN = {32'd0, 32'd50};
        INADDRESS = {5'd0, 5'd1};
        WRITE = 2'b01;
        BUSY_SET = 1'b1;
        BUSY_ADDR = 5'd1;
        tick();
        idle();
        OUTADDRESS = {5'd1, 5'd1};
        #1;
        n_checks++;
        if (OUT !== {32'd50, 32'd50} || ANY_BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset got %h/%b want %h/1",
                     OUT, ANY_BUSY, {32'd50, 32'd50});
        end
        #2;
        RESET = 1'b0;
        #1;
        n_checks++;
        if (OUT !== 64'd0 || ANY_BUSY !== 1'b0 || OUT_BUSY !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset got %h/%b/%b want 0/0/00",
                     OUT, ANY_BUSY, OUT_BUSY);
        end
        tick();
        RESET = 1'b1;
        #1;
        n_checks++;
        if (OUT !== 64'd0 || ANY_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got %h/%b want 0/0", OUT, ANY_BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_zero_reg();
        test_conflict();
        test_scoreboard();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
